load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: REG_LEN, `REG_LEN from rysy_pkg.vh (32), data/address width.
REQ-002 Parameter: TIMEOUT_CYC, 255, max cycles to wait for mem_ack before abort (1..255).
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 Port list, one per line (clock and reset first):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- lsu_valid  in  1  request strobe from execute stage
- lsu_ready  out  1  unit can accept a request
- lsu_we  in  1  1=store, 0=load
- lsu_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr  in  REG_LEN  byte address, taken from ALU alu_out
- lsu_wdata  in  REG_LEN  store data (rs2)
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  qualifies lsu_done: request failed
- lsu_err_code  out  2  00 none, 01 misaligned, 10 illegal op, 11 timeout
- lsu_rdata  out  REG_LEN  formatted load result, valid with lsu_done
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  REG_LEN  word-aligned address (bits [1:0]=00)
- mem_be  out  4  byte enables
- mem_wdata  out  REG_LEN  lane-replicated store data
- mem_ack  in  1  memory completion; mem_rdata valid same cycle
- mem_rdata  in  REG_LEN  memory read word

Function
REQ-005 FSM states: IDLE, REQ, DONE; lsu_ready=1 only in IDLE.
REQ-006 IDLE: lsu_valid=1 registers lsu_we/op/addr/wdata; the checks in REQ-007 are evaluated on the inputs in that cycle.
REQ-007 Check order: illegal first (op in {011,110,111}, or lsu_we=1 with op[2]=1), then misaligned (H/HU with addr[0]=1; W with addr[1:0]!=00).
REQ-008 Failed check: enter DONE with lsu_err=1 and the matching code; mem_req never asserted.
REQ-009 Passed check: enter REQ; mem_req=1 from the next cycle; mem_addr={addr[31:2],2'b00}; all mem_* outputs stable while in REQ.
REQ-010 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1; W 4'b1111; loads drive the same mem_be.
REQ-011 Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-012 REQ with mem_ack=1: capture mem_rdata and go to DONE; mem_req=0 from the next cycle.
REQ-013 Load formatting: select byte addr[1:0] or halfword addr[1]; B/H sign-extend to REG_LEN; BU/HU zero-extend; W passes through.
REQ-014 Stores complete with lsu_rdata=0.
REQ-015 Timeout: 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
REQ-016 Reaching TIMEOUT_CYC without ack: enter DONE with lsu_err=1, code 11, lsu_rdata=0.
REQ-017 mem_ack in the same cycle as timeout expiry: ack wins, no error.
REQ-018 DONE lasts exactly one cycle: lsu_done=1, then IDLE; lsu_err, lsu_err_code and lsu_rdata are valid only while lsu_done=1 and are 0 otherwise.
REQ-019 lsu_valid while lsu_ready=0 is ignored (not queued); mem_ack outside REQ is ignored.
REQ-020 Latency, accept edge = cycle 0: ack in cycle 1 gives lsu_done in cycle 2; error detection gives lsu_done in cycle 1.
REQ-021 Back-to-back throughput: one request per 3 cycles minimum.

Reset
REQ-022 rst_n=0 at a clock edge: state IDLE, counter 0; lsu_ready=1 and all other outputs 0 from the following cycle.
REQ-023 Reset overrides any state, including REQ mid-transaction: mem_req drops after that edge, no lsu_done is produced, and a later mem_ack is ignored.

Verification
REQ-024 LB addr 0x103, mem_rdata 0x80FF_FF12 acked in cycle 1 -> mem_be 1000, mem_addr 0x100, cycle 2 lsu_done=1, lsu_rdata 0xFFFF_FF80.
REQ-025 LHU addr 0x202, mem_rdata 0x9ABC_1234 -> mem_be 1100, lsu_rdata 0x0000_9ABC; LH with the same data -> 0xFFFF_9ABC.
REQ-026 SB addr 0x301, wdata 0x1234_56A5 -> mem_we=1, mem_be 0010, mem_wdata 0xA5A5_A5A5; SH addr 0x302 -> mem_be 1100, mem_wdata 0x56A5_56A5.
REQ-027 LW addr 0x102 -> cycle 1 lsu_done=1, lsu_err=1, code 01, mem_req stays 0; SW with op 100 -> code 10.
REQ-028 LW with mem_ack never asserted, TIMEOUT_CYC=4 -> mem_req high 4 cycles, then lsu_done=1, code 11; repeat with ack on the 4th cycle -> no error.
REQ-029 rst_n low during REQ, then ack -> no lsu_done; lsu_ready=1 after reset; a new request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time from the execute stage, checks it,
// runs a single-beat memory handshake with a timeout, and formats load results.
module load_store_unit #(
  parameter int REG_LEN     = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic               lsu_we,
  input  logic [2:0]         lsu_op,
  input  logic [REG_LEN-1:0] lsu_addr,
  input  logic [REG_LEN-1:0] lsu_wdata,
  output logic               lsu_done,
  output logic               lsu_err,
  output logic [1:0]         lsu_err_code,
  output logic [REG_LEN-1:0] lsu_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [REG_LEN-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [REG_LEN-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [REG_LEN-1:0] mem_rdata
);

  // Handshake: a request is taken on a rising edge where lsu_valid and lsu_ready
  // are both 1; lsu_valid while not ready is dropped. mem_req is held with every
  // mem_* field stable until a rising edge sees mem_ack=1.
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_next;

  logic               we_r;
  logic [2:0]         op_r;
  logic [REG_LEN-1:0] addr_r;
  logic [3:0]         be_r;
  logic [REG_LEN-1:0] wdata_r;
  logic               err_r;
  logic [1:0]         code_r;
  logic [REG_LEN-1:0] rdata_r;
  logic [7:0]         cnt_r;

  logic               illegal;
  logic               misaligned;
  logic [3:0]         be_in;
  logic [REG_LEN-1:0] wdata_in;
  logic [REG_LEN-1:0] load_fmt;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic               expire;

  assign illegal    = (lsu_op == 3'b011) || (lsu_op[2:1] == 2'b11) || (lsu_we && lsu_op[2]);
  assign misaligned = ((lsu_op[1:0] == 2'b01) && lsu_addr[0]) ||
                      ((lsu_op[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
  assign expire     = (cnt_r == 8'(TIMEOUT_CYC - 1));

  always_comb begin
    be_in    = 4'b0000;
    wdata_in = '0;
    case (lsu_op[1:0])
      2'b00: begin
        be_in    = 4'b0001 << lsu_addr[1:0];
        wdata_in = {(REG_LEN/8){lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_in    = lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {(REG_LEN/16){lsu_wdata[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = lsu_wdata;
      end
    endcase
    if (!lsu_we) wdata_in = '0;
  end

  // Lane selection uses the byte offset kept from the original request address.
  always_comb begin
    byte_sel = mem_rdata[{addr_r[1:0], 3'b000} +: 8];
    half_sel = addr_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_r)
      3'b000:  load_fmt = {{(REG_LEN-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {{(REG_LEN-8){1'b0}}, byte_sel};
      3'b001:  load_fmt = {{(REG_LEN-16){half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {{(REG_LEN-16){1'b0}}, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (lsu_valid) state_next = (illegal || misaligned) ? DONE : REQ;
      REQ:  if (mem_ack || expire) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_r    <= 1'b0;
      op_r    <= 3'b000;
      addr_r  <= '0;
      be_r    <= 4'b0000;
      wdata_r <= '0;
      err_r   <= 1'b0;
      code_r  <= 2'b00;
      rdata_r <= '0;
      cnt_r   <= 8'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (lsu_valid) begin
          we_r    <= lsu_we;
          op_r    <= lsu_op;
          addr_r  <= lsu_addr;
          be_r    <= be_in;
          wdata_r <= wdata_in;
          err_r   <= illegal || misaligned;
          code_r  <= illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
          rdata_r <= '0;
          cnt_r   <= 8'd0;
        end
        REQ: begin
          // An ack in the expiry cycle still completes the access normally.
          if (mem_ack) begin
            rdata_r <= we_r ? '0 : load_fmt;
          end else if (expire) begin
            err_r   <= 1'b1;
            code_r  <= 2'b11;
            rdata_r <= '0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          err_r   <= 1'b0;
          code_r  <= 2'b00;
          rdata_r <= '0;
        end
      endcase
    end
  end

  assign lsu_ready    = (state == IDLE);
  assign lsu_done     = (state == DONE);
  assign lsu_err      = lsu_done && err_r;
  assign lsu_err_code = lsu_done ? code_r : 2'b00;
  assign lsu_rdata    = lsu_done ? rdata_r : '0;

  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && we_r;
  assign mem_addr  = mem_req ? {addr_r[REG_LEN-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_r : 4'b0000;
  assign mem_wdata = mem_req ? wdata_r : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drivers push expected responses into queues,
// independent monitors pop and compare on memory requests and on lsu_done.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_ready, lsu_we;
  logic [2:0]  lsu_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_done, lsu_err;
  logic [1:0]  lsu_err_code;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_unit #(.REG_LEN(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_op(lsu_op),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_err_code(lsu_err_code), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  // {done_cycle[31:0], err, code[1:0], rdata[31:0]}
  logic [66:0] exp_q[$];
  // {req_cycles[7:0], we, be[3:0], addr[31:0], wdata[31:0]}
  logic [76:0] mem_q[$];

  int          ack_delay = 0;
  logic [31:0] ack_data  = 32'h0;
  logic        stray_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int req_cyc;
    req_cyc   = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        req_cyc++;
        mem_ack = (ack_delay > 0) && (req_cyc == ack_delay);
      end else begin
        req_cyc = 0;
        mem_ack = stray_ack;
      end
      mem_rdata = ack_data;
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic [66:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (lsu_done === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got lsu_done=1 at cycle %0d, expected 0", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e[66:35]));
            chk("lsu_err", 64'(lsu_err), 64'(e[34]));
            chk("lsu_err_code", 64'(lsu_err_code), 64'(e[33:32]));
            chk("lsu_rdata", 64'(lsu_rdata), 64'(e[31:0]));
          end
        end else begin
          chk("idle_rsp_zero", 64'({lsu_err, lsu_err_code, lsu_rdata}), 64'h0);
        end
      end
    end
  end

  // ---------------- memory-side monitor ----------------
  initial begin
    logic [76:0] cur;
    logic        prev, active;
    int          cnt;
    prev = 1'b0; active = 1'b0; cnt = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_req === 1'b1) begin
          if (!prev) begin
            cnt = 0;
            if (mem_q.size() == 0) begin
              active = 1'b0;
              n_vec++;
              n_err++;
              $display("FAIL unexpected_mem_req: got mem_req=1 at cycle %0d, expected 0", cyc);
            end else begin
              cur    = mem_q.pop_front();
              active = 1'b1;
            end
          end
          cnt++;
          if (active) begin
            chk("mem_we_be", 64'({mem_we, mem_be}), 64'(cur[68:64]));
            chk("mem_addr", 64'(mem_addr), 64'(cur[63:32]));
            chk("mem_wdata", 64'(mem_wdata), 64'(cur[31:0]));
          end
        end else if (prev && active) begin
          chk("mem_req_cycles", 64'(cnt), 64'(cur[76:69]));
          active = 1'b0;
        end
        prev = (mem_req === 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_at, input logic [31:0] rd,
                       input logic do_rsp, input logic [34:0] rsp, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (lsu_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (lsu_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_wait: got lsu_ready=%b, expected 1", lsu_ready);
    end
    ack_delay = ack_at;
    ack_data  = rd;
    lsu_valid = 1'b1;
    lsu_we    = we;
    lsu_op    = op;
    lsu_addr  = addr;
    lsu_wdata = wdata;
    if (do_rsp) exp_q.push_back({32'(cyc + lat), rsp});
    @(posedge clk);
    #1;
    lsu_valid = 1'b0;
  endtask

  task automatic ld(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd,
                    input int ack_at, input logic [3:0] be, input logic [31:0] rdata);
    mem_q.push_back({8'(ack_at), 1'b0, be, addr & ~32'h3, 32'h0});
    issue(1'b0, op, addr, 32'h0, ack_at, rd, 1'b1, {1'b0, 2'b00, rdata}, ack_at + 1);
  endtask

  task automatic st(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] be, input logic [31:0] mwdata);
    mem_q.push_back({8'd1, 1'b1, be, addr & ~32'h3, mwdata});
    issue(1'b1, op, addr, wdata, 1, 32'hFFFF_FFFF, 1'b1, {1'b0, 2'b00, 32'h0}, 2);
  endtask

  task automatic bad(input logic we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [1:0] code);
    issue(we, op, addr, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1'b1, {1'b1, code, 32'h0}, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_op = 3'b000;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'h1);
    chk("rst_lsu_done", 64'(lsu_done), 64'h0);
    chk("rst_lsu_err", 64'({lsu_err, lsu_err_code}), 64'h0);
    chk("rst_lsu_rdata", 64'(lsu_rdata), 64'h0);
    chk("rst_mem_req", 64'({mem_req, mem_we, mem_be}), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // loads: lane selection and sign/zero extension
    ld(3'b000, 32'h0000_0103, 32'h80FF_FF12, 1, 4'b1000, 32'hFFFF_FF80);
    ld(3'b101, 32'h0000_0202, 32'h9ABC_1234, 2, 4'b1100, 32'h0000_9ABC);
    ld(3'b001, 32'h0000_0202, 32'h9ABC_1234, 1, 4'b1100, 32'hFFFF_9ABC);
    ld(3'b100, 32'h0000_0101, 32'h80FF_FF12, 1, 4'b0010, 32'h0000_00FF);
    ld(3'b000, 32'h0000_0100, 32'h80FF_FF12, 1, 4'b0001, 32'h0000_0012);
    ld(3'b001, 32'h0000_0200, 32'h9ABC_1234, 1, 4'b0011, 32'h0000_1234);
    ld(3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 3, 4'b1111, 32'hDEAD_BEEF);

    // stores: lane replication, result data zero
    st(3'b000, 32'h0000_0301, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
    st(3'b001, 32'h0000_0302, 32'h1234_56A5, 4'b1100, 32'h56A5_56A5);
    st(3'b010, 32'h0000_0308, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // rejected requests: illegal has priority over misaligned
    bad(1'b0, 3'b010, 32'h0000_0102, 2'b01);
    bad(1'b1, 3'b100, 32'h0000_0103, 2'b10);
    bad(1'b0, 3'b011, 32'h0000_0100, 2'b10);
    bad(1'b0, 3'b110, 32'h0000_0101, 2'b10);
    bad(1'b0, 3'b001, 32'h0000_0201, 2'b01);
    bad(1'b1, 3'b010, 32'h0000_0302, 2'b01);

    // timeout with no ack, then ack landing on the final allowed cycle
    mem_q.push_back({8'd4, 1'b0, 4'b1111, 32'h0000_0100, 32'h0});
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'h5555_5555, 1'b1, {1'b1, 2'b11, 32'h0}, 5);
    ld(3'b010, 32'h0000_0100, 32'h1357_2468, 4, 4'b1111, 32'h1357_2468);

    // request presented while busy must be dropped
    ld(3'b010, 32'h0000_0108, 32'h0BAD_F00D, 3, 4'b1111, 32'h0BAD_F00D);
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_op = 3'b010; lsu_addr = 32'h0000_0400;
    @(negedge clk);
    lsu_valid = 1'b0;

    // reset in the middle of a memory request, then a stray ack
    mem_q.push_back({8'd2, 1'b0, 4'b1111, 32'h0000_0100, 32'h0});
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'h1111_1111, 1'b0, 35'h0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    chk("ready_after_reset", 64'(lsu_ready), 64'h1);
    chk("mem_req_after_reset", 64'(mem_req), 64'h0);
    ld(3'b000, 32'h0000_0103, 32'h80FF_FF12, 1, 4'b1000, 32'hFFFF_FF80);

    n = 0;
    while ((exp_q.size() != 0 || mem_req === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
    chk("mem_q_drained", 64'(mem_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
